// File: rtl/partial_case_pkg.sv
// Purpose : shared select encodings for the partial-case selector.
// Contents: SEL_* constants for the 2-bit source select.
package partial_case_pkg;

  localparam logic [1:0] SEL_I2I1   = 2'b00;  // x<=i2, y<=i1
  localparam logic [1:0] SEL_HOLD   = 2'b01;  // x<=i1, y holds
  localparam logic [1:0] SEL_I0I2_A = 2'b10;  // x<=i0, y<=i2
  localparam logic [1:0] SEL_I0I2_B = 2'b11;  // alias of SEL_I0I2_A

endpackage

// File: rtl/partial_case_next.sv
// Purpose : combinational next-state decode for partial_case_assign_reg.
// Ports   : sel            source select
//           i0, i1, i2     data inputs
//           x_next         next value for x (always loaded)
//           y_next         next value for y
//           y_load         load enable for y (low only for SEL_HOLD)
module partial_case_next
  import partial_case_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next,
  output logic             y_load
);

  // The default branch also absorbs an unknown sel in simulation, so an
  // undriven select behaves like the 1x encodings.
  always_comb begin
    x_next = i0;
    y_next = i2;
    y_load = 1'b1;
    case (sel)
      SEL_I2I1: begin
        x_next = i2;
        y_next = i1;
        y_load = 1'b1;
      end
      SEL_HOLD: begin
        x_next = i1;
        y_next = i2;  // don't-care value; y_load keeps it out of the register
        y_load = 1'b0;
      end
      default: begin
        x_next = i0;
        y_next = i2;
        y_load = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/partial_case_assign_reg.sv
// Purpose : registered 3-input selector; x reloads every cycle, y holds on
//           SEL_HOLD through a register enable (no latch anywhere).
// Ports   : clk      rising-edge clock
//           reset    asynchronous active-high clear of x and y
//           sel      source select
//           i0..i2   data inputs
//           x, y     registered outputs, one cycle after sel/i* are sampled
module partial_case_assign_reg
  import partial_case_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;
  logic             y_load;

  partial_case_next #(.WIDTH(WIDTH)) u_next (
    .sel    (sel),
    .i0     (i0),
    .i1     (i1),
    .i2     (i2),
    .x_next (x_next),
    .y_next (y_next),
    .y_load (y_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
    end else begin
      x <= x_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else if (y_load) begin
      y <= y_next;
    end
  end

endmodule

// File: tb/tb_partial_case_assign_reg.sv
module tb_partial_case_assign_reg;

  localparam int WIDTH = 1;

  logic             clk;
  logic             reset;
  logic [1:0]       sel;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] x_exp;
  logic [WIDTH-1:0] y_exp;

  partial_case_assign_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .x     (x),
    .y     (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written reference of the next-state table, applied to the model.
  task automatic model_step(input logic [1:0] s, input logic [WIDTH-1:0] a0,
                            input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2);
    if (s == 2'b00) begin
      x_exp = a2;
      y_exp = a1;
    end else if (s == 2'b01) begin
      x_exp = a1;
    end else begin
      x_exp = a0;
      y_exp = a2;
    end
  endtask

  initial begin
    logic [5:0] pat;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    sel = 2'b00;
    i0 = '0;
    i1 = '1;
    i2 = '1;

    // Reset asserted with no clock edge, then held over toggling inputs.
    #2 reset = 1'b1;
    #1;
    check("rst_x_noedge", x, 1'b0);
    check("rst_y_noedge", y, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sel = k[1:0];
      i0 = ~i0;
      i1 = ~i1;
      i2 = ~i2;
      tick();
      check("rst_x_held", x, 1'b0);
      check("rst_y_held", y, 1'b0);
    end
    reset = 1'b0;

    // sel=00 loads x<=i2, y<=i1; later input changes without an edge are ignored.
    sel = 2'b00; i0 = 1'b1; i1 = 1'b1; i2 = 1'b0;
    tick();
    check("s00_x", x, 1'b0);
    check("s00_y", y, 1'b1);
    i1 = 1'b0; i2 = 1'b1;
    #3;
    check("noedge_x", x, 1'b0);
    check("noedge_y", y, 1'b1);

    // Hold: y stays 1 while i2 toggles, x follows i1.
    sel = 2'b01; i1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i2 = k[0];
      tick();
      check("hold_x", x, 1'b0);
      check("hold_y", y, 1'b1);
    end

    // sel=10 and sel=11 behave identically.
    sel = 2'b10; i0 = 1'b1; i2 = 1'b0;
    tick();
    check("s10_x", x, 1'b1);
    check("s10_y", y, 1'b0);
    sel = 2'b00; i1 = 1'b1; i2 = 1'b0;
    tick();
    check("s00_reload_y", y, 1'b1);
    sel = 2'b11; i0 = 1'b1; i2 = 1'b0;
    tick();
    check("s11_x", x, 1'b1);
    check("s11_y", y, 1'b0);

    // Sweep sel 00->01->10->11->00 with free-running data inputs.
    x_exp = x;
    y_exp = 1'b0;
    for (int c = 0; c < 16; c++) begin
      pat = 6'(c * 13 + 5);
      sel = 2'(c);
      i0 = pat[0];
      i1 = pat[2];
      i2 = pat[4];
      model_step(sel, i0, i1, i2);
      tick();
      check("sweep_x", x, x_exp);
      check("sweep_y", y, y_exp);
    end

    // Async reset while y is held at 1.
    sel = 2'b00; i1 = 1'b1; i0 = 1'b0; i2 = 1'b0;
    tick();
    sel = 2'b01; i1 = 1'b1;
    tick();
    check("prehold_y", y, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_x", x, 1'b0);
    check("async_y", y, 1'b0);
    reset = 1'b0;
    sel = 2'b01; i0 = 1'b1; i1 = 1'b1; i2 = 1'b1;
    tick();
    check("post_hold_x", x, 1'b1);
    check("post_hold_y", y, 1'b0);
    sel = 2'b00; i1 = 1'b1; i2 = 1'b0;
    tick();
    check("post_load_x", x, 1'b0);
    check("post_load_y", y, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
